// File: rtl/win_prob_est.sv
// Windowed ones-counter that turns a stochastic bitstream into a fixed-point probability estimate.
// Optional bipolar output oBip is enabled by defining WIN_PROB_EST_BIPOLAR_EN.
module win_prob_est #(
  parameter int BITWIDTH  = 8,
  parameter int FBITWIDTH = 4
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iClr,
  input  logic                  iEn,
  input  logic [BITWIDTH-1:0]   iWINLOG2,
  input  logic                  iBit,
  input  logic                  iReady,
  output logic                  oValid,
  output logic [BITWIDTH:0]     oOnes,
  output logic [FBITWIDTH-1:0]  oProb,
`ifdef WIN_PROB_EST_BIPOLAR_EN
  output logic signed [FBITWIDTH:0] oBip,
`endif
  output logic                  oOverrun
);

  localparam logic [BITWIDTH-1:0] MAXWL = BITWIDTH'(BITWIDTH);
  localparam logic [BITWIDTH:0]   ONE   = (BITWIDTH+1)'(1);

  logic [BITWIDTH-1:0]          pos;
  logic [BITWIDTH:0]            acc;
  logic [BITWIDTH-1:0]          wlReg;
  logic [BITWIDTH-1:0]          wlIn;
  logic [BITWIDTH-1:0]          wlCur;
  logic [BITWIDTH-1:0]          lastPos;
  logic                         lastBit;
  logic                         load;
  logic [BITWIDTH:0]            onesNext;
  logic [BITWIDTH+FBITWIDTH-1:0] scaled;
  logic [FBITWIDTH-1:0]         probNext;

  // The window length is taken live from the input at position 0 and held in wlReg for the rest
  // of the window, so mid-window changes of iWINLOG2 only apply from the next window.
  always_comb begin
    wlIn     = (iWINLOG2 > MAXWL) ? MAXWL : iWINLOG2;
    wlCur    = (pos == '0) ? wlIn : wlReg;
    lastPos  = BITWIDTH'((ONE << wlCur) - ONE);
    lastBit  = iEn && (pos == lastPos);
    onesNext = acc + (BITWIDTH+1)'(iBit);
    scaled   = (BITWIDTH+FBITWIDTH)'(onesNext) << (FBITWIDTH-1);
    probNext = FBITWIDTH'(scaled >> wlCur);
    load     = lastBit && (!oValid || iReady);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      pos      <= '0;
      acc      <= '0;
      wlReg    <= '0;
      oValid   <= 1'b0;
      oOnes    <= '0;
      oProb    <= '0;
      oOverrun <= 1'b0;
    end else if (iClr) begin
      pos      <= '0;
      acc      <= '0;
      wlReg    <= wlIn;
      oValid   <= 1'b0;
      oOnes    <= '0;
      oProb    <= '0;
      oOverrun <= 1'b0;
    end else begin
      if (iEn) begin
        wlReg <= wlCur;
        if (lastBit) begin
          pos <= '0;
          acc <= '0;
        end else begin
          pos <= pos + BITWIDTH'(1);
          acc <= onesNext;
        end
      end
      // A completed window whose result cannot be delivered is dropped and flagged.
      if (lastBit && oValid && !iReady) begin
        oOverrun <= 1'b1;
      end
      if (load) begin
        oValid <= 1'b1;
        oOnes  <= onesNext;
        oProb  <= probNext;
      end else if (oValid && iReady) begin
        oValid <= 1'b0;
      end
    end
  end

`ifdef WIN_PROB_EST_BIPOLAR_EN
  localparam logic [FBITWIDTH:0] HALF = (FBITWIDTH+1)'(1) << (FBITWIDTH-1);

  logic [FBITWIDTH:0] bipNext;

  // 2*prob - 1.0 wraps correctly in FBITWIDTH+1 bits because the result lies in [-1.0, +1.0].
  assign bipNext = {probNext, 1'b0} - HALF;

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      oBip <= '0;
    end else if (load) begin
      oBip <= bipNext;
    end
  end
`endif

endmodule
